// File: rtl/gb_oam_dma_pkg.sv
// gb_oam_dma_pkg
// Shared types and constants for the OAM DMA engine and the memory unit
// that hosts it.
//   dma_state_t  : DMA engine states (IDLE, START, XFER, DRAIN)
//   DMA_REG_ADDR : CPU address of the DMA trigger register
//   OAM_BASE     : first OAM byte, default destination of a transfer
//   OAM_SIZE     : OAM size in bytes, default transfer length
//   echo_map()   : folds echo-RAM source pages back onto work RAM
package gb_oam_dma_pkg;

  typedef enum logic [1:0] {
    s_DMA_IDLE,
    s_DMA_START,
    s_DMA_XFER,
    s_DMA_DRAIN
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam int          OAM_SIZE     = 160;

  // Pages above the limit mirror work RAM: clearing bit 5 maps
  // 0xE0 -> 0xC0 ... 0xFE -> 0xDE.
  function automatic logic [7:0] echo_map(input logic [7:0] page,
                                          input logic [7:0] limit);
    return (page > limit) ? (page & 8'hDF) : page;
  endfunction

endpackage

// File: rtl/gb_oam_dma_if.sv
// gb_oam_dma_if
// Bus between the memory unit (master) and the OAM DMA engine (slave).
//   trig_we/trig_data : CPU write strobe to 0xFF46 and the source page
//   rd_en/rd_addr     : DMA read request; rd_data returns one cycle later
//   wr_en/wr_addr/wr_data : OAM write strobe, address and data
//   busy/cpu_block    : transfer in progress; memory unit gates CPU selects
//   done              : one-cycle pulse after the final write
// Handshake: there is no back-pressure. A read issued with rd_en in cycle n
// must have its data on rd_data in cycle n+1; wr_en is a single-cycle strobe
// that the bank always accepts.
interface gb_oam_dma_if;
  logic        trig_we;
  logic [7:0]  trig_data;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        cpu_block;
  logic        done;

  modport master (
    output trig_we, trig_data, rd_data,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, cpu_block, done
  );

  modport slave (
    input  trig_we, trig_data, rd_data,
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, cpu_block, done
  );
endinterface

// File: rtl/gb_oam_dma.sv
// gb_oam_dma
// OAM DMA engine: on a CPU write to 0xFF46 copies LEN bytes from
// {src_page, 8'h00} to DST_BASE + index through the dedicated bank ports.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bus (slave) : trigger, read port, write port, busy/cpu_block/done
//   o_dbg_state : current FSM state
// Build option GB_DMA_PIPELINE_EN: when defined a read is issued every cycle
// and the write of byte i overlaps the read of byte i+1 (LEN + 1 transfer
// cycles). When undefined, reads and writes alternate (2*LEN cycles).
module gb_oam_dma
  import gb_oam_dma_pkg::*;
#(
  parameter int          LEN         = OAM_SIZE,
  parameter logic [15:0] DST_BASE    = OAM_BASE,
  parameter int          START_DELAY = 1,
  parameter logic [7:0]  ECHO_LIMIT  = 8'hDF
) (
  input  logic             clk,
  input  logic             rst,
  gb_oam_dma_if.slave      bus,
  output dma_state_t       o_dbg_state
);

`ifdef GB_DMA_PIPELINE_EN
  localparam logic PIPELINE = 1'b1;
`else
  localparam logic PIPELINE = 1'b0;
`endif

  // Terminal index compared before increment, so LEN = 256 never wraps.
  localparam logic [7:0] IDX_LAST = 8'(LEN - 1);
  localparam logic [1:0] DLY_LAST = (START_DELAY > 0) ? 2'(START_DELAY - 1) : 2'd0;
  localparam dma_state_t LAUNCH   = (START_DELAY > 0) ? s_DMA_START : s_DMA_XFER;

  dma_state_t r_state;
  dma_state_t w_state_nxt;
  logic [7:0] r_page;
  logic [7:0] r_idx;
  logic [7:0] r_wr_idx;
  logic [1:0] r_dly;
  logic       r_wr_pend;
  logic       r_done;
  logic       w_rd_fire;
  logic       w_last_rd;
  logic       w_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_rd_fire   = 1'b0;
    w_last_rd   = 1'b0;
    case (r_state)
      s_DMA_START: if (r_dly == DLY_LAST) w_state_nxt = s_DMA_XFER;
      s_DMA_XFER: begin
        // Non-pipelined: a read is only issued when no write is pending.
        w_rd_fire = PIPELINE || !r_wr_pend;
        w_last_rd = w_rd_fire && (r_idx == IDX_LAST);
        if (w_last_rd) w_state_nxt = s_DMA_DRAIN;
      end
      s_DMA_DRAIN: w_state_nxt = s_DMA_IDLE;
      default: ;
    endcase
    // A trigger restarts the engine from any state.
    if (bus.trig_we) w_state_nxt = LAUNCH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= s_DMA_IDLE;
      r_page    <= 8'h00;
      r_idx     <= 8'h00;
      r_wr_idx  <= 8'h00;
      r_dly     <= 2'd0;
      r_wr_pend <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      // A read issued in a retrigger cycle belongs to the aborted transfer,
      // so its write is dropped; the write already on the bus completes.
      r_wr_pend <= w_rd_fire && !bus.trig_we;
      r_done    <= (r_state == s_DMA_DRAIN) && !bus.trig_we;
      if (w_rd_fire) r_wr_idx <= r_idx;
      if (bus.trig_we) begin
        r_page <= echo_map(bus.trig_data, ECHO_LIMIT);
        r_idx  <= 8'h00;
        r_dly  <= 2'd0;
      end else begin
        if (r_state == s_DMA_START) r_dly <= r_dly + 2'd1;
        if (w_rd_fire && !w_last_rd) r_idx <= r_idx + 8'd1;
      end
    end
  end

  assign w_busy        = (r_state != s_DMA_IDLE);
  assign bus.rd_en     = w_rd_fire;
  assign bus.rd_addr   = w_rd_fire ? {r_page, r_idx} : 16'h0000;
  assign bus.wr_en     = r_wr_pend;
  assign bus.wr_addr   = r_wr_pend ? (DST_BASE + {8'h00, r_wr_idx}) : 16'h0000;
  assign bus.wr_data   = r_wr_pend ? bus.rd_data : 8'h00;
  assign bus.busy      = w_busy;
  assign bus.cpu_block = w_busy;
  assign bus.done      = r_done;
  assign o_dbg_state   = r_state;

endmodule
